// File: rtl/prbs31_burst_ctrl_pkg.sv
// Shared types and constants for the PRBS31 burst sequencer.
// Optional error injection is enabled with the PRBS_ERR_INJECT_EN macro.
package prbs_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEED = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int unsigned PRBS31_TAP_A = 30;
  localparam int unsigned PRBS31_TAP_B = 27;
  localparam logic [30:0] PRBS31_LOCKUP_SEED = 31'h7FFF_FFFF;

endpackage

// File: rtl/prbs31_burst_ctrl_if.sv
// Control/status bundle for prbs31_burst_ctrl, plus FSM and LFSR debug taps.
// err_inject/err_count exist only when PRBS_ERR_INJECT_EN is defined.
interface prbs31_burst_ctrl_if #(
  parameter int DIV_W = 16,
  parameter int LEN_W = 16
);
  import prbs_pkg::*;

  // start/abort are level-sampled on each clk edge (no handshake); bit_valid
  // and done are single-cycle pulses that the consumer must accept when high.
  logic             start;
  logic             abort;
  logic [30:0]      seed;
  logic [DIV_W-1:0] div;
  logic [LEN_W-1:0] len;
  logic             bit_out;
  logic             bit_valid;
  logic             busy;
  logic             done;
  logic [LEN_W-1:0] bit_count;
  state_t           state_dbg;
  logic [30:0]      lfsr_dbg;
`ifdef PRBS_ERR_INJECT_EN
  logic             err_inject;
  logic [7:0]       err_count;

  modport master (
    output start, abort, seed, div, len, err_inject,
    input  bit_out, bit_valid, busy, done, bit_count, state_dbg, lfsr_dbg, err_count
  );
  modport slave (
    input  start, abort, seed, div, len, err_inject,
    output bit_out, bit_valid, busy, done, bit_count, state_dbg, lfsr_dbg, err_count
  );
`else
  modport master (
    output start, abort, seed, div, len,
    input  bit_out, bit_valid, busy, done, bit_count, state_dbg, lfsr_dbg
  );
  modport slave (
    input  start, abort, seed, div, len,
    output bit_out, bit_valid, busy, done, bit_count, state_dbg, lfsr_dbg
  );
`endif

endinterface

// File: rtl/prbs31_burst_ctrl_lfsr.sv
// 31-bit Fibonacci LFSR for x^31+x^28+1; load has priority over advance.
module prbs31_lfsr
  import prbs_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [30:0] load_val,
  input  logic        advance,
  output logic        fb,
  output logic [30:0] state
);

  logic [30:0] lfsr_q;

  assign fb    = lfsr_q[PRBS31_TAP_A] ^ lfsr_q[PRBS31_TAP_B];
  assign state = lfsr_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr_q <= PRBS31_LOCKUP_SEED;
    end else if (load) begin
      lfsr_q <= load_val;
    end else if (advance) begin
      lfsr_q <= {lfsr_q[29:0], fb};
    end
  end

endmodule

// File: rtl/prbs31_burst_ctrl.sv
// PRBS31 burst sequencer: seed load, prescaled bit pacing, burst/continuous modes.
// Define PRBS_ERR_INJECT_EN to add one-shot bit error injection and an error counter.
module prbs31_burst_ctrl
  import prbs_pkg::*;
#(
  parameter int DIV_W = 16,
  parameter int LEN_W = 16
) (
  input logic               clk,
  input logic               rst_n,
  prbs31_burst_ctrl_if.slave bus
);

  state_t           state_q, state_d;
  logic [DIV_W-1:0] prescaler_q;
  logic [LEN_W-1:0] bit_count_q;
  logic             bit_out_q;
  logic             bit_valid_q;
  logic             done_q;

  logic             tick;
  logic             last_bit;
  logic             lfsr_load;
  logic [30:0]      lfsr_load_val;
  logic             lfsr_fb;
  logic [30:0]      lfsr_state;
  logic             invert;

  prbs31_lfsr u_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (lfsr_load),
    .load_val (lfsr_load_val),
    .advance  (tick),
    .fb       (lfsr_fb),
    .state    (lfsr_state)
  );

  // abort wins over a coincident tick so an aborted burst never emits a bit
  always_comb begin
    tick          = (state_q == RUN) && !bus.abort && (prescaler_q == bus.div);
    last_bit      = tick && (bus.len != '0) && ((bit_count_q + LEN_W'(1)) == bus.len);
    lfsr_load     = (state_q == SEED) && !bus.abort;
    lfsr_load_val = (bus.seed == '0) ? PRBS31_LOCKUP_SEED : bus.seed;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.start) state_d = SEED;
      SEED: state_d = bus.abort ? IDLE : RUN;
      RUN: begin
        if (bus.abort)     state_d = IDLE;
        else if (last_bit) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef PRBS_ERR_INJECT_EN
  logic       err_flag_q;
  logic [7:0] err_count_q;

  // a pulse on the tick cycle itself corrupts that tick
  assign invert        = tick && (err_flag_q || bus.err_inject);
  assign bus.err_count = err_count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_flag_q  <= 1'b0;
      err_count_q <= 8'd0;
    end else begin
      if (state_q != RUN || bus.abort || tick) err_flag_q <= 1'b0;
      else if (bus.err_inject)                 err_flag_q <= 1'b1;
      if (invert && err_count_q != 8'hFF)      err_count_q <= err_count_q + 8'd1;
    end
  end
`else
  assign invert = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      prescaler_q <= '0;
      bit_count_q <= '0;
      bit_out_q   <= 1'b0;
      bit_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_valid_q <= tick;
      done_q      <= (state_q == DONE);
      if (tick) bit_out_q <= lfsr_fb ^ invert;

      if (state_q == SEED)                  prescaler_q <= '0;
      else if (state_q == RUN && !bus.abort) prescaler_q <= tick ? '0 : prescaler_q + DIV_W'(1);

      if (state_q == IDLE && bus.start) bit_count_q <= '0;
      else if (tick)                    bit_count_q <= bit_count_q + LEN_W'(1);
    end
  end

  assign bus.bit_out   = bit_out_q;
  assign bus.bit_valid = bit_valid_q;
  assign bus.busy      = (state_q == SEED) || (state_q == RUN);
  assign bus.done      = done_q;
  assign bus.bit_count = bit_count_q;
  assign bus.state_dbg = state_q;
  assign bus.lfsr_dbg  = lfsr_state;

endmodule

// File: tb/tb_prbs31_burst_ctrl.sv
// Directed bench for prbs31_burst_ctrl with a bit scoreboard fed by a PRBS31 model.
// The error-injection section compiles only with PRBS_ERR_INJECT_EN defined.
module tb_prbs31_burst_ctrl;
  import prbs_pkg::*;

  localparam int DIV_W = 16;
  localparam int LEN_W = 16;

  logic clk;
  logic rst_n;
  int   total_cnt;
  int   pass_cnt;
  logic [0:0] exp_q[$];

  prbs31_burst_ctrl_if #(.DIV_W(DIV_W), .LEN_W(LEN_W)) bus ();

  prbs31_burst_ctrl #(.DIV_W(DIV_W), .LEN_W(LEN_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    total_cnt++;
    assert (obs === exp_v) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // reference model: x^31+x^28+1, output bit is the shifted-in feedback
  task automatic push_bits(input logic [30:0] s_in, input int n);
    logic [30:0] s;
    logic        b;
    s = (s_in == '0) ? 31'h7FFF_FFFF : s_in;
    for (int i = 0; i < n; i++) begin
      b = s[30] ^ s[27];
      exp_q.push_back(b);
      s = {s[29:0], b};
    end
  endtask

  // scoreboard: every emitted bit must match the next expected bit
  always @(negedge clk) begin
    if (rst_n && bus.bit_valid === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_bit", bus.bit_valid, 1'b0);
      else                   check("bit_out", bus.bit_out, exp_q.pop_front());
    end
  end

  // driver: start pulse, then cycle-exact checks of valid/done timing
  task automatic run_burst(input string tag, input logic [30:0] s, input int d, input int l);
    int   first;
    int   n_done;
    logic exp_v;
    push_bits(s, l);
    bus.seed  = s;
    bus.div   = d[DIV_W-1:0];
    bus.len   = l[LEN_W-1:0];
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
    check({tag, "_busy_t0"}, bus.busy, 1'b1);
    first  = 2 + d;
    n_done = first + (l - 1) * (d + 1) + 1;
    for (int k = 1; k <= n_done; k++) begin
      step(1);
      exp_v = (k >= first) && (k < n_done) && (((k - first) % (d + 1)) == 0);
      check({tag, "_valid"}, bus.bit_valid, exp_v);
      check({tag, "_done"}, bus.done, (k == n_done));
      if (k == 1) check({tag, "_lfsr_load"}, bus.lfsr_dbg, (s == '0) ? 31'h7FFF_FFFF : s);
    end
    check({tag, "_count"}, bus.bit_count, l[LEN_W-1:0]);
    check({tag, "_busy_end"}, bus.busy, 1'b0);
    check({tag, "_q_drained"}, exp_q.size(), 0);
    step(1);
    check({tag, "_done_clear"}, bus.done, 1'b0);
  endtask

  initial begin
    logic [30:0] rs;
    total_cnt = 0;
    pass_cnt  = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.seed  = '0;
    bus.div   = '0;
    bus.len   = '0;
`ifdef PRBS_ERR_INJECT_EN
    bus.err_inject = 1'b0;
`endif
    step(2);
    check("rst_bit_out", bus.bit_out, 1'b0);
    check("rst_bit_valid", bus.bit_valid, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_bit_count", bus.bit_count, 0);
    check("rst_state", bus.state_dbg, IDLE);
    check("rst_lfsr", bus.lfsr_dbg, 31'h7FFF_FFFF);
    rst_n = 1'b1;
    step(1);

    run_burst("basic", 31'h4000_0000, 0, 4);
    run_burst("lock28", 31'h0, 0, 28);
    run_burst("lock29", 31'h0, 0, 29);
    check("lock29_last_bit", bus.bit_out, 1'b1);
    run_burst("pace", 31'h1234_5678, 3, 3);

    // abort on the cycle of bit 10; a start while busy must be ignored
    push_bits(31'h1357_9BDF, 9);
    bus.seed  = 31'h1357_9BDF;
    bus.div   = '0;
    bus.len   = '0;
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step(1);
      bus.start = 1'b0;
      bus.abort = 1'b0;
      check("abort_valid", bus.bit_valid, (k >= 2) && (k <= 10));
      check("abort_busy", bus.busy, (k <= 10));
      check("abort_count", bus.bit_count, (k <= 1) ? 0 : ((k <= 10) ? k - 1 : 9));
      check("abort_done", bus.done, 1'b0);
      if (k == 3)  bus.start = 1'b1;
      if (k == 10) bus.abort = 1'b1;
    end
    check("abort_state", bus.state_dbg, IDLE);
    check("abort_q_drained", exp_q.size(), 0);

    // reset asserted mid-RUN in continuous mode
    push_bits(31'h2A5A_5A5A, 1);
    bus.seed  = 31'h2A5A_5A5A;
    bus.div   = 16'd2;
    bus.len   = '0;
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
    step(6);
    check("midrun_busy_before", bus.busy, 1'b1);
    rst_n = 1'b0;
    step(2);
    check("midrun_rst_bit_out", bus.bit_out, 1'b0);
    check("midrun_rst_valid", bus.bit_valid, 1'b0);
    check("midrun_rst_busy", bus.busy, 1'b0);
    check("midrun_rst_done", bus.done, 1'b0);
    check("midrun_rst_count", bus.bit_count, 0);
    check("midrun_rst_state", bus.state_dbg, IDLE);
    check("midrun_q_drained", exp_q.size(), 0);
    rst_n = 1'b1;
    step(1);
    run_burst("post_rst", 31'h2A5A_5A5A, 1, 5);

    for (int i = 0; i < 3; i++) begin
      rs = 31'($urandom());
      run_burst("rand", rs, $urandom_range(0, 2), $urandom_range(1, 6));
    end

`ifdef PRBS_ERR_INJECT_EN
    // first bit inverted (1 -> 0), remaining bits follow the true sequence
    push_bits(31'h4000_0000, 4);
    exp_q[0] = ~exp_q[0];
    bus.seed  = 31'h4000_0000;
    bus.div   = 16'd1;
    bus.len   = 16'd4;
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
    step(1);
    bus.err_inject = 1'b1;
    step(1);
    bus.err_inject = 1'b0;
    step(9);
    check("err_count", bus.err_count, 8'd1);
    check("err_bit_count", bus.bit_count, 4);
    check("err_q_drained", exp_q.size(), 0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
